ysyx_22050058_pc_reg: RTL and testbench
=======================================

YSYX_22050058_PC_REG -- requirements
Module: ysyx_22050058_pc_reg

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port stall  input  6  pipeline stall vector; bit0 = fetch stage.
REQ-005 SHALL have port flush  input  6  pipeline flush vector; bit0 = fetch stage.
REQ-006 SHALL have port branch_flag  input  1  branch/jump redirect request from decode/execute.
REQ-007 SHALL have port branch_target  input  64  branch destination.
REQ-008 SHALL have port trap_target  input  64  trap/mret destination, valid while flush[0]=1.
REQ-009 SHALL have port pc  output  64  fetch address driven to the instruction ROM addr input.
REQ-010 SHALL have port ce  output  1  fetch enable to the instruction ROM.
REQ-011 SHALL have port pend_valid  output  1  a redirect is held awaiting stall release.
REQ-012 SHALL have port misalign  output  1  pc[1:0] != 0 while ce=1.

Function
REQ-013 SHALL implement FSM states RESET, BOOT, RUN.
REQ-014 SHALL enter RESET while rst=1; go RESET->BOOT on the first cycle rst=0; go BOOT->RUN after one cycle; stay in RUN until rst.
REQ-015 SHALL drive ce=0 in RESET and ce=1 in BOOT and RUN.
REQ-016 SHALL hold pc=RESET_VECTOR in RESET and BOOT, so the ROM fetches RESET_VECTOR first.
REQ-017 SHALL, in RUN, update pc each cycle by this priority, highest first:
  (a) flush[0]=1: pc<=trap_target; clear pending.
  (b) stall[0]=1 and branch_flag=1: hold pc; capture branch_target into pending (newest request overwrites older).
  (c) stall[0]=1: hold pc.
  (d) pending valid: pc<=pending target; clear pending.
  (e) branch_flag=1: pc<=branch_target.
  (f) otherwise: pc<=pc+4.
REQ-018 SHALL compute pc+4 modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
REQ-019 SHALL give flush[0] priority over stall[0] and over any pending redirect.
REQ-020 SHALL ignore branch_flag, flush and stall in RESET and BOOT; BOOT always advances to RUN.
REQ-021 SHALL drive pend_valid combinationally from the pending-valid register.
REQ-022 SHALL register the redirect target, with a latency of 1 cycle from branch_flag (unstalled) to pc.
REQ-023 SHALL drive misalign combinationally from ce and pc[1:0], and SHALL still load misaligned targets; trap handling belongs downstream.

Reset
REQ-024 SHALL, one cycle after rst is sampled high, hold pc=RESET_VECTOR, ce=0, pend_valid=0, misalign=0, state=RESET.
REQ-025 SHALL discard any pending redirect when rst is asserted mid-operation, and SHALL restart via RESET->BOOT->RUN.

Structure
REQ-026 SHALL take StallEnable/Disable, FlushEnable, ChipEnable/Disable, ZeroWord and the InstAdderBus width from the shared ysyx_22050058_define file; the FSM state encodings SHALL be added there.
REQ-027 SHALL place the pending-redirect register pair (valid, target) in one sub-module, ysyx_22050058_redirect_buf; the FSM and pc mux stay in the top.

Verification
REQ-028 SHALL cover boot: rst=1 for 3 cycles, then release -> ce=0 while in reset; BOOT cycle pc=0x80000000 with ce=1; then pc=0x80000004, 0x80000008 on successive cycles.
REQ-029 SHALL cover an unstalled branch: in RUN at pc=0x80000010, branch_flag=1 with target 0x80000100 -> next pc=0x80000100, then 0x80000104.
REQ-030 SHALL cover a branch under stall: stall[0]=1 for 3 cycles, branch to 0x80000200 in cycle 1 and to 0x80000300 in cycle 2 -> pc held, pend_valid=1; first cycle after release pc=0x80000300, pend_valid=0.
REQ-031 SHALL cover trap vs stall: stall[0]=1, flush[0]=1, trap_target=0x80000800, pending valid -> next pc=0x80000800, pend_valid=0.
REQ-032 SHALL cover wrap and misalignment: branch to 0xFFFFFFFFFFFFFFFC -> next pc=0; branch to 0x80000002 -> misalign=1 while that pc is held.
REQ-033 SHALL cover mid-run reset: rst=1 while pend_valid=1 -> next cycle pend_valid=0, ce=0, pc=0x80000000.

Source files
------------

// File: rtl/ysyx_22050058_define_pkg.sv
// ysyx_22050058_define_pkg: shared control encodings, bus widths and fetch FSM states
package ysyx_22050058_define_pkg;
  localparam logic STALL_ENABLE = 1'b1;
  localparam logic STALL_DISABLE = 1'b0;
  localparam logic FLUSH_ENABLE = 1'b1;
  localparam logic CHIP_ENABLE = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam int INST_ADDR_BUS = 64;
  localparam logic [INST_ADDR_BUS-1:0] ZERO_WORD = '0;
  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_BOOT = 2'd1,
    ST_RUN = 2'd2
  } pc_state_e;
endpackage

// File: rtl/ysyx_22050058_redirect_buf.sv
// ysyx_22050058_redirect_buf: holds one redirect target while fetch is stalled
module ysyx_22050058_redirect_buf
  import ysyx_22050058_define_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     capture,
  input  logic                     clear,
  input  logic [INST_ADDR_BUS-1:0] target_in,
  output logic                     valid,
  output logic [INST_ADDR_BUS-1:0] target
);
  always_ff @(posedge clk) begin
    valid <= (rst || clear) ? 1'b0 : (capture ? 1'b1 : valid);
    target <= rst ? ZERO_WORD : (capture ? target_in : target);
  end
endmodule

// File: rtl/ysyx_22050058_pc_reg.sv
// ysyx_22050058_pc_reg: fetch pc with boot sequencing, stall/flush priority and deferred redirects
module ysyx_22050058_pc_reg
  import ysyx_22050058_define_pkg::*;
#(
  parameter logic [INST_ADDR_BUS-1:0] RESET_VECTOR = 64'h0000_0000_8000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [5:0]               stall,
  input  logic [5:0]               flush,
  input  logic                     branch_flag,
  input  logic [INST_ADDR_BUS-1:0] branch_target,
  input  logic [INST_ADDR_BUS-1:0] trap_target,
  output logic [INST_ADDR_BUS-1:0] pc,
  output logic                     ce,
  output logic                     pend_valid,
  output logic                     misalign
);
  pc_state_e state, state_nxt;
  logic [INST_ADDR_BUS-1:0] pc_nxt, pc_inc, pend_target;
  logic run, stall_f, flush_f;
  logic unused_stages;
  assign unused_stages = ^{stall[5:1], flush[5:1]};
  assign stall_f = stall[0] == STALL_ENABLE;
  assign flush_f = flush[0] == FLUSH_ENABLE;
  assign run = state == ST_RUN;
  assign pc_inc = pc + INST_ADDR_BUS'(4);
  always_ff @(posedge clk) begin
    state <= rst ? ST_RESET : state_nxt;
  end
  always_comb begin
    state_nxt = (state == ST_RESET) ? ST_BOOT : ST_RUN;
  end
  always_comb begin
    ce = (state == ST_RESET) ? CHIP_DISABLE : CHIP_ENABLE;
    misalign = ce && (pc[1:0] != 2'b00);
  end
  // Leaving BOOT steps past the vector already fetched during the BOOT cycle.
  always_comb begin
    pc_nxt = !run ? ((state == ST_BOOT) ? pc_inc : RESET_VECTOR) :
             flush_f ? trap_target :
             stall_f ? pc :
             pend_valid ? pend_target :
             branch_flag ? branch_target : pc_inc;
  end
  always_ff @(posedge clk) begin
    pc <= rst ? RESET_VECTOR : pc_nxt;
  end
  ysyx_22050058_redirect_buf u_redirect_buf (
    .clk      (clk),
    .rst      (rst),
    .capture  (run && !flush_f && stall_f && branch_flag),
    .clear    (!run || flush_f || !stall_f),
    .target_in(branch_target),
    .valid    (pend_valid),
    .target   (pend_target)
  );
endmodule

// File: tb/tb_ysyx_22050058_pc_reg.sv
// tb_ysyx_22050058_pc_reg: directed boot/branch/stall/trap/wrap/reset scenarios plus randomized run vs model
module tb_ysyx_22050058_pc_reg;
  localparam logic [63:0] RV = 64'h0000_0000_8000_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] stall = '0, flush = '0;
  logic branch_flag = 1'b0;
  logic [63:0] branch_target = '0, trap_target = '0;
  logic [63:0] pc;
  logic ce, pend_valid, misalign;
  int checks = 0, fails = 0;
  int m_phase = 0;
  logic [63:0] m_pc = RV;
  logic m_pend = 1'b0;
  logic [63:0] m_pend_t = '0;
  always #5 clk = ~clk;
  ysyx_22050058_pc_reg #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .branch_flag(branch_flag),
    .branch_target(branch_target), .trap_target(trap_target),
    .pc(pc), .ce(ce), .pend_valid(pend_valid), .misalign(misalign)
  );
  // Reference: phase 0 reset, 1 boot, 2 run; redirect rules applied in priority order.
  task automatic step();
    if (rst) begin
      m_phase = 0; m_pc = RV; m_pend = 0;
    end else if (m_phase == 0) m_phase = 1;
    else if (m_phase == 1) begin
      m_phase = 2; m_pc = RV + 4;
    end else if (flush[0]) begin
      m_pc = trap_target; m_pend = 0;
    end else if (stall[0]) begin
      if (branch_flag) begin
        m_pend = 1; m_pend_t = branch_target;
      end
    end else if (m_pend) begin
      m_pc = m_pend_t; m_pend = 0;
    end else m_pc = branch_flag ? branch_target : m_pc + 64'd4;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({pc, ce, pend_valid, misalign} !== {RV, 3'b000}) begin
        fails++; $display("FAIL reset[%0d]: pc=%h ce=%b pv=%b mis=%b want pc=%h ce=0 pv=0 mis=0", i, pc, ce, pend_valid, misalign, RV);
      end
    end
    rst = 0;
    step();
    checks++;
    if ({pc, ce} !== {64'h8000_0000, 1'b1}) begin
      fails++; $display("FAIL boot: pc=%h ce=%b want 80000000/1", pc, ce);
    end
    step();
    checks++;
    if (pc !== 64'h8000_0004) begin fails++; $display("FAIL run1: pc=%h want 80000004", pc); end
    step();
    checks++;
    if (pc !== 64'h8000_0008) begin fails++; $display("FAIL run2: pc=%h want 80000008", pc); end
  endtask
  task automatic test_branch();
    step(); step();
    checks++;
    if (pc !== 64'h8000_0010) begin fails++; $display("FAIL br_pre: pc=%h want 80000010", pc); end
    branch_flag = 1; branch_target = 64'h8000_0100;
    step();
    branch_flag = 0;
    checks++;
    if (pc !== 64'h8000_0100) begin fails++; $display("FAIL br_take: pc=%h want 80000100", pc); end
    step();
    checks++;
    if (pc !== 64'h8000_0104) begin fails++; $display("FAIL br_next: pc=%h want 80000104", pc); end
  endtask
  task automatic test_stall_branch();
    logic [63:0] held;
    held = pc;
    stall = 6'b000001; branch_flag = 1; branch_target = 64'h8000_0200;
    step();
    branch_target = 64'h8000_0300;
    step();
    branch_flag = 0;
    step();
    checks++;
    if ({pc, pend_valid} !== {held, 1'b1}) begin
      fails++; $display("FAIL stall_hold: pc=%h pv=%b want %h/1", pc, pend_valid, held);
    end
    stall = 0;
    step();
    checks++;
    if ({pc, pend_valid} !== {64'h8000_0300, 1'b0}) begin
      fails++; $display("FAIL stall_release: pc=%h pv=%b want 80000300/0", pc, pend_valid);
    end
    step();
    checks++;
    if (pc !== 64'h8000_0304) begin fails++; $display("FAIL stall_after: pc=%h want 80000304", pc); end
  endtask
  task automatic test_trap();
    stall = 6'b000001; branch_flag = 1; branch_target = 64'h8000_0400;
    step();
    branch_flag = 0;
    checks++;
    if (pend_valid !== 1'b1) begin fails++; $display("FAIL trap_pend: pv=%b want 1", pend_valid); end
    flush = 6'b000001; trap_target = 64'h8000_0800;
    step();
    stall = 0; flush = 0;
    checks++;
    if ({pc, pend_valid} !== {64'h8000_0800, 1'b0}) begin
      fails++; $display("FAIL trap: pc=%h pv=%b want 80000800/0", pc, pend_valid);
    end
  endtask
  task automatic test_wrap_misalign();
    branch_flag = 1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    branch_flag = 0;
    step();
    checks++;
    if (pc !== 64'h0) begin fails++; $display("FAIL wrap: pc=%h want 0", pc); end
    branch_flag = 1; branch_target = 64'h8000_0002;
    step();
    branch_flag = 0; stall = 6'b000001;
    checks++;
    if ({pc, misalign} !== {64'h8000_0002, 1'b1}) begin
      fails++; $display("FAIL misalign: pc=%h mis=%b want 80000002/1", pc, misalign);
    end
    step();
    stall = 0;
    checks++;
    if ({pc, misalign} !== {64'h8000_0002, 1'b1}) begin
      fails++; $display("FAIL misalign_hold: pc=%h mis=%b want 80000002/1", pc, misalign);
    end
  endtask
  task automatic test_mid_reset();
    stall = 6'b000001; branch_flag = 1; branch_target = 64'h8000_0500;
    step();
    checks++;
    if (pend_valid !== 1'b1) begin fails++; $display("FAIL mr_pend: pv=%b want 1", pend_valid); end
    rst = 1;
    step();
    checks++;
    if ({pc, ce, pend_valid} !== {RV, 2'b00}) begin
      fails++; $display("FAIL mid_reset: pc=%h ce=%b pv=%b want %h/0/0", pc, ce, pend_valid, RV);
    end
    rst = 0;
    step(); step();
    stall = 0; branch_flag = 0;
    checks++;
    if ({pc, ce, pend_valid} !== {RV + 64'd4, 2'b10}) begin
      fails++; $display("FAIL mr_restart: pc=%h ce=%b pv=%b want 80000004/1/0", pc, ce, pend_valid);
    end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      branch_flag = 1; branch_target = 64'h9000_0000 + 64'(i * 64);
      step();
      checks++;
      if (pc !== 64'h9000_0000 + 64'(i * 64)) begin
        fails++; $display("FAIL b2b[%0d]: pc=%h want %h", i, pc, 64'h9000_0000 + 64'(i * 64));
      end
    end
    branch_flag = 0;
  endtask
  task automatic test_random();
    logic m_ce;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      stall = 6'($urandom) & 6'b111110 | 6'($urandom_range(0, 9) < 3);
      flush = 6'($urandom) & 6'b111110 | 6'($urandom_range(0, 9) == 0);
      branch_flag = ($urandom_range(0, 9) < 3);
      branch_target = {$urandom, $urandom} & ~64'($urandom_range(0, 3) != 0 ? 3 : 0);
      trap_target = {$urandom, $urandom};
      step();
      m_ce = (m_phase != 0);
      checks++;
      if ({pc, ce, pend_valid, misalign} !== {m_pc, m_ce, m_pend, m_ce && (m_pc[1:0] != 0)}) begin
        fails++;
        $display("FAIL random[%0d]: pc=%h ce=%b pv=%b mis=%b want pc=%h ce=%b pv=%b mis=%b",
                 i, pc, ce, pend_valid, misalign, m_pc, m_ce, m_pend, m_ce && (m_pc[1:0] != 0));
      end
    end
    rst = 0; stall = 0; flush = 0; branch_flag = 0;
  endtask
  initial begin
    test_reset();
    test_branch();
    test_stall_branch();
    test_trap();
    test_wrap_misalign();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
